// File: rtl/lfsr_prbs_generator_pkg.sv
// Shared types and constants for the parametrised LFSR/PRBS generator.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIBONACCI = 1'b0,
    LFSR_GALOIS    = 1'b1
  } lfsr_mode_e;

  // Maximal-length masks; bit WIDTH-1 set so they also suit the Galois form
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  localparam int unsigned WIDTH_MIN    = 3;
  localparam int unsigned WIDTH_MAX    = 64;
  localparam int unsigned OUT_BITS_MIN = 1;
  localparam int unsigned OUT_BITS_MAX = 64;

endpackage

// File: rtl/lfsr_prbs_generator_if.sv
// Output word stream of the PRBS generator (valid/ready handshake).
interface lfsr_prbs_generator_if #(
  parameter int unsigned OUT_BITS = 8
);
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/lfsr_prbs_generator_multi_step.sv
// Combinational unrolling of OUT_BITS LFSR steps in either topology.
module lfsr_multi_step
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  TAPS     = TAPS_16,
  parameter int unsigned       OUT_BITS = 8
) (
  input  logic [WIDTH-1:0]    state,
  input  lfsr_mode_e          mode,
  input  logic [WIDTH-1:0]    seed_ref,
  output logic [OUT_BITS-1:0] bits,
  output logic [WIDTH-1:0]    next_state,
  output logic [OUT_BITS-1:0] match
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s     = state;
    bits  = '0;
    match = '0;
    for (int unsigned i = 0; i < OUT_BITS; i++) begin
      bits[i] = s[0];
      if (mode == LFSR_GALOIS)
        s = (s >> 1) ^ (s[0] ? TAPS : '0);
      else
        s = {^(s & TAPS), s[WIDTH-1:1]};
      match[i] = (s == seed_ref);
    end
    next_state = s;
  end

endmodule

// File: rtl/lfsr_prbs_generator.sv
// Multi-bit PRBS generator: state/seed registers, stream handshake,
// all-zero lockup recovery and period-wrap detection.
module lfsr_prbs_generator
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  TAPS     = TAPS_16,
  parameter int unsigned       OUT_BITS = 8,
  parameter logic [WIDTH-1:0]  SEED     = WIDTH'(1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  lfsr_prbs_generator_if.master stream,
  output logic [WIDTH-1:0]     state_out,
  output logic                 lockup_event,
  output logic                 period_wrap
);

  logic [WIDTH-1:0]    state_q;
  logic [WIDTH-1:0]    seed_ref_q;
  logic                valid_q;
  logic [OUT_BITS-1:0] data_q;
  logic                lockup_q;
  logic                wrap_q;

  logic [OUT_BITS-1:0] step_bits;
  logic [WIDTH-1:0]    step_state;
  logic [OUT_BITS-1:0] step_match;
  logic                advance;

  lfsr_multi_step #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .OUT_BITS (OUT_BITS)
  ) u_multi_step (
    .state      (state_q),
    .mode       (lfsr_mode_e'(mode)),
    .seed_ref   (seed_ref_q),
    .bits       (step_bits),
    .next_state (step_state),
    .match      (step_match)
  );

  assign advance = enable && !seed_load && (!valid_q || stream.out_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SEED;
      seed_ref_q <= SEED;
      valid_q    <= 1'b0;
      data_q     <= '0;
      lockup_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
      if (seed_load) begin
        valid_q <= 1'b0;
        if (seed_in == '0) begin
          state_q    <= SEED;
          seed_ref_q <= SEED;
          lockup_q   <= 1'b1;
        end else begin
          state_q    <= seed_in;
          seed_ref_q <= seed_in;
        end
      end else if (advance) begin
        data_q  <= step_bits;
        valid_q <= 1'b1;
        wrap_q  <= |step_match;
        // The emitted bits stay as computed; only the stored state is recovered
        if (step_state == '0) begin
          state_q  <= SEED;
          lockup_q <= 1'b1;
        end else begin
          state_q <= step_state;
        end
      end else if (valid_q && stream.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign state_out        = state_q;
  assign lockup_event     = lockup_q;
  assign period_wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_prbs_generator.sv
// Bench for lfsr_prbs_generator: three 4-bit configurations sharing inputs,
// hand-derived vector table, corner sequences and randomized model comparison.
module tb_lfsr_prbs_generator;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       seed_load = 1'b0;
  logic [3:0] seed_in = 4'h0;
  logic       ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // a: Galois-style taps C, 4 bits/word; b: taps 3, 4 bits/word; c: taps C, 1 bit/word
  lfsr_prbs_generator_if #(.OUT_BITS(4)) if_a ();
  lfsr_prbs_generator_if #(.OUT_BITS(4)) if_b ();
  lfsr_prbs_generator_if #(.OUT_BITS(1)) if_c ();

  logic [3:0] st_a, st_b, st_c;
  logic       lk_a, lk_b, lk_c, wp_a, wp_b, wp_c;

  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;
  assign if_c.out_ready = ready;

  lfsr_prbs_generator #(.WIDTH(4), .TAPS(4'hC), .OUT_BITS(4), .SEED(4'h1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .stream(if_a), .state_out(st_a), .lockup_event(lk_a), .period_wrap(wp_a));

  lfsr_prbs_generator #(.WIDTH(4), .TAPS(4'h3), .OUT_BITS(4), .SEED(4'h1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .stream(if_b), .state_out(st_b), .lockup_event(lk_b), .period_wrap(wp_b));

  lfsr_prbs_generator #(.WIDTH(4), .TAPS(4'hC), .OUT_BITS(1), .SEED(4'h1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .stream(if_c), .state_out(st_c), .lockup_event(lk_c), .period_wrap(wp_c));

  logic       act_v [3];
  logic [3:0] act_d [3];
  logic [3:0] act_s [3];
  logic       act_l [3];
  logic       act_w [3];

  assign act_v[0] = if_a.out_valid;  assign act_d[0] = if_a.out_data;
  assign act_v[1] = if_b.out_valid;  assign act_d[1] = if_b.out_data;
  assign act_v[2] = if_c.out_valid;  assign act_d[2] = {3'b000, if_c.out_data};
  assign act_s[0] = st_a; assign act_l[0] = lk_a; assign act_w[0] = wp_a;
  assign act_s[1] = st_b; assign act_l[1] = lk_b; assign act_w[1] = wp_b;
  assign act_s[2] = st_c; assign act_l[2] = lk_c; assign act_w[2] = wp_c;

  // Reference model: one record per DUT, stepped at transaction level
  logic       m_v [3];
  logic [3:0] m_d [3];
  logic [3:0] m_s [3];
  logic [3:0] m_ref [3];
  logic       m_l [3];
  logic       m_w [3];

  function automatic logic [3:0] cfg_taps(input int k);
    return (k == 1) ? 4'h3 : 4'hC;
  endfunction

  function automatic int cfg_nbits(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // Produce n bits from start state using arithmetic forms of the step rules
  function automatic void gen_word(input logic [3:0] start, input bit galois,
                                   input logic [3:0] taps, input int n, input logic [3:0] ref_s,
                                   output logic [3:0] word, output logic [3:0] fin, output bit hit);
    int s;
    int fb;
    s = int'(start);
    word = 4'h0;
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      word[i] = s[0];
      if (galois) begin
        s = (s % 2 == 1) ? ((s / 2) ^ int'(taps)) : (s / 2);
      end else begin
        fb = $countones(4'(s) & taps) % 2;
        s = s / 2 + fb * 8;
      end
      if (4'(s) == ref_s) hit = 1'b1;
    end
    fin = 4'(s);
  endfunction

  task automatic model_update(input int k);
    logic [3:0] w, f;
    bit h;
    m_l[k] = 1'b0;
    m_w[k] = 1'b0;
    if (!reset) begin
      m_s[k] = 4'h1; m_ref[k] = 4'h1; m_v[k] = 1'b0; m_d[k] = 4'h0;
    end else if (seed_load) begin
      m_v[k] = 1'b0;
      m_s[k] = (seed_in == 4'h0) ? 4'h1 : seed_in;
      m_ref[k] = m_s[k];
      m_l[k] = (seed_in == 4'h0);
    end else if (enable && (!m_v[k] || ready)) begin
      gen_word(m_s[k], mode, cfg_taps(k), cfg_nbits(k), m_ref[k], w, f, h);
      m_d[k] = w;
      m_v[k] = 1'b1;
      m_w[k] = h;
      m_l[k] = (f == 4'h0);
      m_s[k] = (f == 4'h0) ? 4'h1 : f;
    end else if (m_v[k] && ready) begin
      m_v[k] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic string dname(input int k);
    return (k == 0) ? "a" : (k == 1) ? "b" : "c";
  endfunction

  task automatic tick();
    for (int k = 0; k < 3; k++) model_update(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check({"model.", dname(k), ".valid"}, 64'(act_v[k]), 64'(m_v[k]));
      check({"model.", dname(k), ".data"},  64'(act_d[k]), 64'(m_d[k]));
      check({"model.", dname(k), ".state"}, 64'(act_s[k]), 64'(m_s[k]));
      check({"model.", dname(k), ".lockup"}, 64'(act_l[k]), 64'(m_l[k]));
      check({"model.", dname(k), ".wrap"},  64'(act_w[k]), 64'(m_w[k]));
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic md, input logic sl,
                       input logic [3:0] si, input logic rdy);
    reset = r; enable = en; mode = md; seed_load = sl; seed_in = si; ready = rdy;
  endtask

  typedef struct {
    logic rst_n, en, md, sl;
    logic [3:0] sin;
    logic rdy;
    logic v;
    logic [3:0] d, st;
    logic lk, wp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [3:0] hold_d, hold_s;
    int wraps;

    // Hand-derived expectations for dut_a (taps C, 4 bits/word, SEED 1)
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0,  1'b0, 4'h0, 4'h1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1,  1'b1, 4'h9, 4'hD, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1,  1'b1, 4'h5, 4'h7, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0,  1'b1, 4'h5, 4'h7, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1,  1'b0, 4'h5, 4'h7, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1,  1'b0, 4'h5, 4'h1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1,  1'b1, 4'h1, 4'h1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1,  1'b0, 4'h1, 4'h1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1,  1'b0, 4'h1, 4'h7, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1,  1'b1, 4'hF, 4'h8, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].md, tbl[i].sl, tbl[i].sin, tbl[i].rdy);
      tick();
      check($sformatf("tbl[%0d].valid", i), 64'(if_a.out_valid), 64'(tbl[i].v));
      check($sformatf("tbl[%0d].data", i),  64'(if_a.out_data),  64'(tbl[i].d));
      check($sformatf("tbl[%0d].state", i), 64'(st_a),           64'(tbl[i].st));
      check($sformatf("tbl[%0d].lockup", i), 64'(lk_a),          64'(tbl[i].lk));
      check($sformatf("tbl[%0d].wrap", i),  64'(wp_a),           64'(tbl[i].wp));
    end

    // Fibonacci with taps 3 from reset: first word 1, state 9
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    check("fib.b.data", 64'(if_b.out_data), 64'h1);
    check("fib.b.state", 64'(st_b), 64'h9);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    // Restore dut_a to the tbl[9] situation: seed 7, Galois word F pending
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    tick();

    // Backpressure: word F / state 8 must hold for 5 stalled cycles
    hold_d = if_a.out_data;
    hold_s = st_a;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.valid", 64'(if_a.out_valid), 64'h1);
      check("bp.data", 64'(if_a.out_data), 64'(hold_d));
      check("bp.state", 64'(st_a), 64'(hold_s));
    end
    check("bp.held_word", 64'(hold_d), 64'hF);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    check("bp.next_data", 64'(if_a.out_data), 64'h8);
    check("bp.next_state", 64'(st_a), 64'hC);

    // Zero seed while a word is pending
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0);
    tick();
    check("zseed.valid", 64'(if_a.out_valid), 64'h0);
    check("zseed.state", 64'(st_a), 64'h1);
    check("zseed.lockup", 64'(lk_a), 64'h1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    check("zseed.lockup_clear", 64'(lk_a), 64'h0);

    // Reset with seed_load mid-stream, then period checks from seed_ref=SEED
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1);
    tick();
    check("rst.valid", 64'(if_a.out_valid), 64'h0);
    check("rst.data", 64'(if_a.out_data), 64'h0);
    check("rst.state", 64'(st_a), 64'h1);
    check("rst.lockup", 64'(lk_a), 64'h0);
    check("rst.wrap", 64'(wp_a), 64'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    wraps = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (wp_c) wraps++;
      if (t < 4) check($sformatf("rst.a.wrap[%0d]", t), 64'(wp_a), (t == 3) ? 64'h1 : 64'h0);
    end
    check("period.c.wrap_count", 64'(wraps), 64'h1);
    check("period.c.wrap_last", 64'(wp_c), 64'h1);
    check("period.c.state", 64'(st_c), 64'h1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    tick();
    check("period.c.wrap_one_cycle", 64'(wp_c), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_generator.md
Name: lfsr_prbs_generator

Overview:
- Parametrised successor to the single-bit shift-register generator.
- Generalises width, tap polynomial and topology (Fibonacci/Galois), and emits OUT_BITS pseudo-random bits per cycle over a valid/ready stream.
- Adds run-time seed load, all-zero lockup recovery and a period-wrap indication.
- Feeds test-pattern, arbitration-randomisation and scrambler logic inside the vector chip.

Parameters:
- WIDTH, 16, state register length; legal 3..64.
- TAPS, 16'hB400, feedback mask of WIDTH bits; must be nonzero; TAPS[WIDTH-1] must be 1 for Galois maximal length.
- OUT_BITS, 8, bits produced per accepted word; legal 1..64.
- SEED, 1, reset and fallback seed; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- enable  in  1  permits generation of new words
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every advance
- seed_load  in  1  load seed_in this cycle
- seed_in  in  WIDTH  run-time seed
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts the word
- out_data  out  OUT_BITS  generated bits; bit 0 is the earliest bit
- state_out  out  WIDTH  current internal state
- lockup_event  out  1  one-cycle pulse: zero state or zero seed was replaced by SEED
- period_wrap  out  1  one-cycle pulse: sequence returned to its seed reference

Behaviour:
- Reset (reset==0 at posedge clk) sets: state=SEED, seed_ref=SEED, out_valid=0, out_data=0, lockup_event=0, period_wrap=0. Reset has highest priority.
- Single Fibonacci step from state s:
  - Output bit is s[0].
  - fb = XOR-reduce(s & TAPS).
  - Next state is {fb, s[WIDTH-1:1]}.
- Single Galois step from state s:
  - Output bit is s[0].
  - Next state is (s >> 1) XOR (s[0] ? TAPS : 0).
- Advance condition: enable && !seed_load && (!out_valid || out_ready). On advance:
  - out_data[i] = output bit of step i, for i = 0..OUT_BITS-1.
  - state = state after OUT_BITS steps.
  - out_valid = 1.
  - Latency from the advance cycle to out_valid is 1 cycle. Throughput is 1 word per cycle while out_ready is held high.
- If out_valid && out_ready and there is no advance: out_valid = 0.
- While out_valid && !out_ready, out_data and state are held stable regardless of enable.
- If enable is low, a pending word is still accepted normally; no new word is produced.
- seed_load (priority below reset only):
  - state = seed_in, seed_ref = seed_in, out_valid = 0. Any pending word is discarded.
  - If seed_in == 0: state and seed_ref take SEED instead, and lockup_event pulses the next cycle.
  - The first word from the new seed appears no earlier than the cycle after the load.
- Lockup: if the post-advance state would be all-zero, load SEED instead and pulse lockup_event. The out_data bits of that word are still those computed.
- period_wrap: pulses in the cycle after an advance if any intermediate state after steps 1..OUT_BITS equals seed_ref.
- mode changes take effect on the next advance. No flush is required.
- Outputs lockup_event and period_wrap are registered, one cycle wide, and never held.

Decomposition:
- Package lfsr_pkg contains:
  - typedef enum lfsr_mode_e {LFSR_FIBONACCI, LFSR_GALOIS}.
  - Localparam maximal-length tap constants for widths 4, 8, 16, 32.
  - Legal parameter range constants.
- Sub-module lfsr_multi_step: purely combinational, parameterised by WIDTH/TAPS/OUT_BITS. Given state and mode, it returns:
  - the OUT_BITS output bits;
  - the final state;
  - a per-step match vector against seed_ref.
- The top level holds the registers, handshake and lockup/period logic.

Test Plan:
- WIDTH=4, TAPS=4'hC, SEED=1, OUT_BITS=4, mode=Galois, enable=1, out_ready=1 after reset → first out_data=4'h9, state_out=4'hD, out_valid rises 1 cycle after enable.
- Same config, mode=Fibonacci, TAPS=4'h3 → first out_data=4'h1, state_out=4'h9.
- Galois 4-bit config with OUT_BITS=1, run 15 advances → state_out returns to 4'h1 and period_wrap pulses exactly once.
- Hold out_ready=0 for 5 cycles with enable=1 → out_data and state_out stay unchanged, a single word is pending, and no word is lost after out_ready rises.
- seed_load with seed_in=0 while out_valid=1 → out_valid=0 next cycle, state_out=SEED, lockup_event pulses for 1 cycle.
- Assert reset low mid-stream with seed_load also asserted → all outputs return to reset values next cycle and seed_ref=SEED.
